// File: rtl/axi_xbar_1to2_pkg.sv
// axi_xbar_1to2_pkg: shared AXI-Lite types, widths and default address map
package ysyx_23060251;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    typedef logic [1:0] axi_resp_t;
    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_DECERR = 2'b11;
    localparam logic [ADDR_W-1:0] S0_BASE_DEF = 32'h8000_0000;
    localparam logic [ADDR_W-1:0] S0_SIZE_DEF = 32'h0800_0000;
    localparam logic [ADDR_W-1:0] S1_BASE_DEF = 32'ha000_0000;
    localparam logic [ADDR_W-1:0] S1_SIZE_DEF = 32'h0001_0000;
    typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_RSP, RD_ERR} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_RSP, WR_ERR} wr_state_e;
endpackage

// File: rtl/axi_xbar_1to2_addr_decode.sv
// axi_addr_decode: maps an address to slave 0, slave 1 or unmapped
module axi_addr_decode
    import ysyx_23060251::*;
#(
    parameter logic [ADDR_W-1:0] S0_BASE = S0_BASE_DEF,
    parameter logic [ADDR_W-1:0] S0_SIZE = S0_SIZE_DEF,
    parameter logic [ADDR_W-1:0] S1_BASE = S1_BASE_DEF,
    parameter logic [ADDR_W-1:0] S1_SIZE = S1_SIZE_DEF
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              sel_o,
    output logic              err_o
);
    logic hit0, hit1;
    // Offset compare in unsigned 32-bit space keeps regions ending at 2^32 correct
    assign hit0  = (addr_i >= S0_BASE) && (addr_i - S0_BASE < S0_SIZE);
    assign hit1  = (addr_i >= S1_BASE) && (addr_i - S1_BASE < S1_SIZE);
    assign sel_o = !hit0 && hit1;
    assign err_o = !hit0 && !hit1;
endmodule

// File: rtl/axi_xbar_1to2.sv
// axi_xbar_1to2: one-master, two-slave AXI-Lite crossbar with local DECERR
module axi_xbar_1to2
    import ysyx_23060251::*;
#(
    parameter logic [ADDR_W-1:0] S0_BASE = S0_BASE_DEF,
    parameter logic [ADDR_W-1:0] S0_SIZE = S0_SIZE_DEF,
    parameter logic [ADDR_W-1:0] S1_BASE = S1_BASE_DEF,
    parameter logic [ADDR_W-1:0] S1_SIZE = S1_SIZE_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              slv_ar_valid_i,
    input  logic [ADDR_W-1:0] slv_ar_addr_i,
    output logic              slv_ar_ready_o,
    output logic              slv_r_valid_o,
    output logic [DATA_W-1:0] slv_r_data_o,
    output axi_resp_t         slv_r_resp_o,
    input  logic              slv_r_ready_i,
    input  logic              slv_aw_valid_i,
    input  logic [ADDR_W-1:0] slv_aw_addr_i,
    output logic              slv_aw_ready_o,
    input  logic              slv_w_valid_i,
    input  logic [DATA_W-1:0] slv_w_data_i,
    input  logic [STRB_W-1:0] slv_w_strb_i,
    output logic              slv_w_ready_o,
    output logic              slv_b_valid_o,
    output axi_resp_t         slv_b_resp_o,
    input  logic              slv_b_ready_i,
    output logic              m0_ar_valid_o,
    output logic [ADDR_W-1:0] m0_ar_addr_o,
    input  logic              m0_ar_ready_i,
    input  logic              m0_r_valid_i,
    input  logic [DATA_W-1:0] m0_r_data_i,
    input  axi_resp_t         m0_r_resp_i,
    output logic              m0_r_ready_o,
    output logic              m0_aw_valid_o,
    output logic [ADDR_W-1:0] m0_aw_addr_o,
    input  logic              m0_aw_ready_i,
    output logic              m0_w_valid_o,
    output logic [DATA_W-1:0] m0_w_data_o,
    output logic [STRB_W-1:0] m0_w_strb_o,
    input  logic              m0_w_ready_i,
    input  logic              m0_b_valid_i,
    input  axi_resp_t         m0_b_resp_i,
    output logic              m0_b_ready_o,
    output logic              m1_ar_valid_o,
    output logic [ADDR_W-1:0] m1_ar_addr_o,
    input  logic              m1_ar_ready_i,
    input  logic              m1_r_valid_i,
    input  logic [DATA_W-1:0] m1_r_data_i,
    input  axi_resp_t         m1_r_resp_i,
    output logic              m1_r_ready_o,
    output logic              m1_aw_valid_o,
    output logic [ADDR_W-1:0] m1_aw_addr_o,
    input  logic              m1_aw_ready_i,
    output logic              m1_w_valid_o,
    output logic [DATA_W-1:0] m1_w_data_o,
    output logic [STRB_W-1:0] m1_w_strb_o,
    input  logic              m1_w_ready_i,
    input  logic              m1_b_valid_i,
    input  axi_resp_t         m1_b_resp_i,
    output logic              m1_b_ready_o
);
    rd_state_e rd_state_q;
    wr_state_e wr_state_q;
    logic      rd_sel_q, rd_err_q, wr_sel_q, wr_err_q, aw_done_q, w_done_q;
    logic      ar_sel, ar_err, aw_sel, aw_err, aw_hs, w_hs;

    axi_addr_decode #(.S0_BASE(S0_BASE), .S0_SIZE(S0_SIZE), .S1_BASE(S1_BASE), .S1_SIZE(S1_SIZE))
        u_ar_dec (.addr_i(slv_ar_addr_i), .sel_o(ar_sel), .err_o(ar_err));
    axi_addr_decode #(.S0_BASE(S0_BASE), .S0_SIZE(S0_SIZE), .S1_BASE(S1_BASE), .S1_SIZE(S1_SIZE))
        u_aw_dec (.addr_i(slv_aw_addr_i), .sel_o(aw_sel), .err_o(aw_err));

    // Address, data and strobe go to both slaves; only the valids are steered
    assign m0_ar_addr_o = slv_ar_addr_i;
    assign m1_ar_addr_o = slv_ar_addr_i;
    assign m0_aw_addr_o = slv_aw_addr_i;
    assign m1_aw_addr_o = slv_aw_addr_i;
    assign m0_w_data_o  = slv_w_data_i;
    assign m1_w_data_o  = slv_w_data_i;
    assign m0_w_strb_o  = slv_w_strb_i;
    assign m1_w_strb_o  = slv_w_strb_i;
    assign aw_hs        = slv_aw_valid_i && slv_aw_ready_o;
    assign w_hs         = slv_w_valid_i && slv_w_ready_o;

    // Read channel steering; IDLE drives nothing so decode costs one cycle
    always_comb begin
        slv_ar_ready_o = 1'b0;
        slv_r_valid_o  = 1'b0;
        slv_r_data_o   = '0;
        slv_r_resp_o   = RESP_OKAY;
        m0_ar_valid_o  = 1'b0;
        m1_ar_valid_o  = 1'b0;
        m0_r_ready_o   = 1'b0;
        m1_r_ready_o   = 1'b0;
        case (rd_state_q)
            RD_REQ: begin
                m0_ar_valid_o  = slv_ar_valid_i && !rd_err_q && !rd_sel_q;
                m1_ar_valid_o  = slv_ar_valid_i && !rd_err_q && rd_sel_q;
                slv_ar_ready_o = rd_err_q || (rd_sel_q ? m1_ar_ready_i : m0_ar_ready_i);
            end
            RD_RSP: begin
                slv_r_valid_o = rd_sel_q ? m1_r_valid_i : m0_r_valid_i;
                slv_r_data_o  = rd_sel_q ? m1_r_data_i : m0_r_data_i;
                slv_r_resp_o  = rd_sel_q ? m1_r_resp_i : m0_r_resp_i;
                m0_r_ready_o  = slv_r_ready_i && !rd_sel_q;
                m1_r_ready_o  = slv_r_ready_i && rd_sel_q;
            end
            RD_ERR: begin
                slv_r_valid_o = 1'b1;
                slv_r_resp_o  = RESP_DECERR;
            end
            default: ;
        endcase
    end

    // Read FSM: latch the decode, track the single outstanding read
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_state_q <= RD_IDLE;
            rd_sel_q   <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            case (rd_state_q)
                RD_IDLE: if (slv_ar_valid_i) begin
                    rd_sel_q   <= ar_sel;
                    rd_err_q   <= ar_err;
                    rd_state_q <= RD_REQ;
                end
                RD_REQ:  if (rd_err_q) rd_state_q <= RD_ERR;
                         else if (slv_ar_valid_i && slv_ar_ready_o) rd_state_q <= RD_RSP;
                RD_RSP:  if (slv_r_valid_o && slv_r_ready_i) rd_state_q <= RD_IDLE;
                RD_ERR:  if (slv_r_ready_i) rd_state_q <= RD_IDLE;
            endcase
        end
    end

    // Write channel steering; AW and W are masked once their beat is taken
    always_comb begin
        slv_aw_ready_o = 1'b0;
        slv_w_ready_o  = 1'b0;
        slv_b_valid_o  = 1'b0;
        slv_b_resp_o   = RESP_OKAY;
        m0_aw_valid_o  = 1'b0;
        m1_aw_valid_o  = 1'b0;
        m0_w_valid_o   = 1'b0;
        m1_w_valid_o   = 1'b0;
        m0_b_ready_o   = 1'b0;
        m1_b_ready_o   = 1'b0;
        case (wr_state_q)
            WR_REQ: begin
                m0_aw_valid_o  = slv_aw_valid_i && !aw_done_q && !wr_err_q && !wr_sel_q;
                m1_aw_valid_o  = slv_aw_valid_i && !aw_done_q && !wr_err_q && wr_sel_q;
                m0_w_valid_o   = slv_w_valid_i && !w_done_q && !wr_err_q && !wr_sel_q;
                m1_w_valid_o   = slv_w_valid_i && !w_done_q && !wr_err_q && wr_sel_q;
                slv_aw_ready_o = !aw_done_q && (wr_err_q || (wr_sel_q ? m1_aw_ready_i : m0_aw_ready_i));
                slv_w_ready_o  = !w_done_q && (wr_err_q || (wr_sel_q ? m1_w_ready_i : m0_w_ready_i));
            end
            WR_RSP: begin
                slv_b_valid_o = wr_sel_q ? m1_b_valid_i : m0_b_valid_i;
                slv_b_resp_o  = wr_sel_q ? m1_b_resp_i : m0_b_resp_i;
                m0_b_ready_o  = slv_b_ready_i && !wr_sel_q;
                m1_b_ready_o  = slv_b_ready_i && wr_sel_q;
            end
            WR_ERR: begin
                slv_b_valid_o = 1'b1;
                slv_b_resp_o  = RESP_DECERR;
            end
            default: ;
        endcase
    end

    // Write FSM: AW/W completion flags allow either order or the same cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_state_q <= WR_IDLE;
            wr_sel_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            case (wr_state_q)
                WR_IDLE: if (slv_aw_valid_i && slv_w_valid_i) begin
                    wr_sel_q   <= aw_sel;
                    wr_err_q   <= aw_err;
                    aw_done_q  <= 1'b0;
                    w_done_q   <= 1'b0;
                    wr_state_q <= WR_REQ;
                end
                WR_REQ: begin
                    aw_done_q <= aw_done_q || aw_hs;
                    w_done_q  <= w_done_q || w_hs;
                    if (wr_err_q) wr_state_q <= WR_ERR;
                    else if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) wr_state_q <= WR_RSP;
                end
                WR_RSP:  if (slv_b_valid_o && slv_b_ready_i) wr_state_q <= WR_IDLE;
                WR_ERR:  if (slv_b_ready_i) wr_state_q <= WR_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_xbar_1to2.sv
// tb_axi_xbar_1to2: directed scenarios with hand-computed expectations
module tb_axi_xbar_1to2;
    logic        clk_i = 1'b0, rst_i = 1'b0;
    logic        slv_ar_valid = 0, slv_ar_ready, slv_r_valid, slv_r_ready = 0;
    logic [31:0] slv_ar_addr = 0, slv_r_data;
    logic [1:0]  slv_r_resp, slv_b_resp;
    logic        slv_aw_valid = 0, slv_aw_ready, slv_w_valid = 0, slv_w_ready, slv_b_valid, slv_b_ready = 0;
    logic [31:0] slv_aw_addr = 0, slv_w_data = 0;
    logic [3:0]  slv_w_strb = 0;
    logic        m0_ar_valid, m0_ar_ready = 0, m0_r_valid = 0, m0_r_ready;
    logic        m0_aw_valid, m0_aw_ready = 0, m0_w_valid, m0_w_ready = 0, m0_b_valid = 0, m0_b_ready;
    logic [31:0] m0_ar_addr, m0_r_data = 0, m0_aw_addr, m0_w_data;
    logic [1:0]  m0_r_resp = 0, m0_b_resp = 0;
    logic [3:0]  m0_w_strb;
    logic        m1_ar_valid, m1_ar_ready = 0, m1_r_valid = 0, m1_r_ready;
    logic        m1_aw_valid, m1_aw_ready = 0, m1_w_valid, m1_w_ready = 0, m1_b_valid = 0, m1_b_ready;
    logic [31:0] m1_ar_addr, m1_r_data = 0, m1_aw_addr, m1_w_data;
    logic [1:0]  m1_r_resp = 0, m1_b_resp = 0;
    logic [3:0]  m1_w_strb;
    logic [14:0] outs;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk_i = ~clk_i;

    assign outs = {slv_ar_ready, slv_r_valid, slv_aw_ready, slv_w_ready, slv_b_valid,
                   m0_ar_valid, m0_r_ready, m0_aw_valid, m0_w_valid, m0_b_ready,
                   m1_ar_valid, m1_r_ready, m1_aw_valid, m1_w_valid, m1_b_ready};

    axi_xbar_1to2 dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .slv_ar_valid_i(slv_ar_valid), .slv_ar_addr_i(slv_ar_addr), .slv_ar_ready_o(slv_ar_ready),
        .slv_r_valid_o(slv_r_valid), .slv_r_data_o(slv_r_data), .slv_r_resp_o(slv_r_resp), .slv_r_ready_i(slv_r_ready),
        .slv_aw_valid_i(slv_aw_valid), .slv_aw_addr_i(slv_aw_addr), .slv_aw_ready_o(slv_aw_ready),
        .slv_w_valid_i(slv_w_valid), .slv_w_data_i(slv_w_data), .slv_w_strb_i(slv_w_strb), .slv_w_ready_o(slv_w_ready),
        .slv_b_valid_o(slv_b_valid), .slv_b_resp_o(slv_b_resp), .slv_b_ready_i(slv_b_ready),
        .m0_ar_valid_o(m0_ar_valid), .m0_ar_addr_o(m0_ar_addr), .m0_ar_ready_i(m0_ar_ready),
        .m0_r_valid_i(m0_r_valid), .m0_r_data_i(m0_r_data), .m0_r_resp_i(m0_r_resp), .m0_r_ready_o(m0_r_ready),
        .m0_aw_valid_o(m0_aw_valid), .m0_aw_addr_o(m0_aw_addr), .m0_aw_ready_i(m0_aw_ready),
        .m0_w_valid_o(m0_w_valid), .m0_w_data_o(m0_w_data), .m0_w_strb_o(m0_w_strb), .m0_w_ready_i(m0_w_ready),
        .m0_b_valid_i(m0_b_valid), .m0_b_resp_i(m0_b_resp), .m0_b_ready_o(m0_b_ready),
        .m1_ar_valid_o(m1_ar_valid), .m1_ar_addr_o(m1_ar_addr), .m1_ar_ready_i(m1_ar_ready),
        .m1_r_valid_i(m1_r_valid), .m1_r_data_i(m1_r_data), .m1_r_resp_i(m1_r_resp), .m1_r_ready_o(m1_r_ready),
        .m1_aw_valid_o(m1_aw_valid), .m1_aw_addr_o(m1_aw_addr), .m1_aw_ready_i(m1_aw_ready),
        .m1_w_valid_o(m1_w_valid), .m1_w_data_o(m1_w_data), .m1_w_strb_o(m1_w_strb), .m1_w_ready_i(m1_w_ready),
        .m1_b_valid_i(m1_b_valid), .m1_b_resp_i(m1_b_resp), .m1_b_ready_o(m1_b_ready)
    );

    // Upstream read plus a responding slave; ar_lat/r_lat are slave delays, rr_lat upstream r_ready delay
    task automatic rd_xact(input logic [31:0] addr, input int ar_lat, input int r_lat, input int rr_lat,
                           input logic [31:0] data, input logic [1:0] resp,
                           output logic done, output logic [31:0] got_data, output logic [1:0] got_resp,
                           output logic s0, output logic s1, output logic [31:0] s_addr, output int vcnt, output logic held);
        int n, k, rn;
        logic hs;
        done = 0; s0 = 0; s1 = 0; vcnt = 0; held = 1; k = -1; n = 0; rn = 0; hs = 0;
        got_data = '0; got_resp = '0; s_addr = '0;
        slv_ar_addr = addr; slv_ar_valid = 1;
        for (int i = 0; i < 40 && !hs; i++) begin
            #1;
            s0 |= m0_ar_valid; s1 |= m1_ar_valid;
            if (m0_ar_valid || m1_ar_valid) begin
                if (n >= ar_lat) begin m0_ar_ready = m0_ar_valid; m1_ar_ready = m1_ar_valid; end
                n++;
            end
            #1;
            hs = slv_ar_ready;
            if (hs && (m0_ar_valid || m1_ar_valid)) begin
                k = m1_ar_valid ? 1 : 0;
                s_addr = m1_ar_valid ? m1_ar_addr : m0_ar_addr;
            end
            @(posedge clk_i); #1;
            m0_ar_ready = 0; m1_ar_ready = 0;
        end
        slv_ar_valid = 0;
        for (int i = 0; i < 40 && hs && !done; i++) begin
            if (rn >= r_lat && k == 0) begin m0_r_valid = 1; m0_r_data = data; m0_r_resp = resp; end
            if (rn >= r_lat && k == 1) begin m1_r_valid = 1; m1_r_data = data; m1_r_resp = resp; end
            rn++;
            #1;
            s0 |= m0_ar_valid; s1 |= m1_ar_valid;
            if (slv_r_valid) begin vcnt++; if (vcnt > rr_lat) slv_r_ready = 1; end
            else if (vcnt > 0) held = 0;
            #1;
            if (slv_r_valid && slv_r_ready) begin done = 1; got_data = slv_r_data; got_resp = slv_r_resp; end
            @(posedge clk_i); #1;
        end
        slv_r_ready = 0; m0_r_valid = 0; m1_r_valid = 0;
    endtask

    // Upstream write plus a responding slave; seen = {m0_aw, m0_w, m1_aw, m1_w} ever valid
    task automatic wr_xact(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lat, input int w_lat, input int b_lat, input int br_lat, input logic [1:0] resp,
                           output logic done, output logic [1:0] got_resp, output logic [3:0] seen,
                           output logic [31:0] s_addr, output logic [31:0] s_data, output logic [3:0] s_strb, output int bcnt);
        int an, wn, k, bn, vc;
        logic ah, wh, a_ok, w_ok;
        done = 0; got_resp = '0; seen = 0; s_addr = '0; s_data = '0; s_strb = '0; bcnt = 0;
        an = 0; wn = 0; k = -1; bn = 0; vc = 0; a_ok = 0; w_ok = 0;
        slv_aw_addr = addr; slv_aw_valid = 1; slv_w_data = data; slv_w_strb = strb; slv_w_valid = 1;
        for (int i = 0; i < 40 && !(a_ok && w_ok); i++) begin
            #1;
            seen |= {m0_aw_valid, m0_w_valid, m1_aw_valid, m1_w_valid};
            if (m0_aw_valid || m1_aw_valid) begin
                if (an >= aw_lat) begin m0_aw_ready = m0_aw_valid; m1_aw_ready = m1_aw_valid; end
                an++;
            end
            if (m0_w_valid || m1_w_valid) begin
                if (wn >= w_lat) begin m0_w_ready = m0_w_valid; m1_w_ready = m1_w_valid; end
                wn++;
            end
            #1;
            ah = slv_aw_valid && slv_aw_ready;
            wh = slv_w_valid && slv_w_ready;
            if (ah && (m0_aw_valid || m1_aw_valid)) begin
                k = m1_aw_valid ? 1 : 0;
                s_addr = m1_aw_valid ? m1_aw_addr : m0_aw_addr;
            end
            if (wh && (m0_w_valid || m1_w_valid)) begin
                s_data = m1_w_valid ? m1_w_data : m0_w_data;
                s_strb = m1_w_valid ? m1_w_strb : m0_w_strb;
            end
            @(posedge clk_i); #1;
            m0_aw_ready = 0; m1_aw_ready = 0; m0_w_ready = 0; m1_w_ready = 0;
            if (ah) begin slv_aw_valid = 0; a_ok = 1; end
            if (wh) begin slv_w_valid = 0; w_ok = 1; end
        end
        slv_aw_valid = 0; slv_w_valid = 0;
        for (int i = 0; i < 40 && a_ok && w_ok && !done; i++) begin
            if (bn >= b_lat && k == 0) begin m0_b_valid = 1; m0_b_resp = resp; end
            if (bn >= b_lat && k == 1) begin m1_b_valid = 1; m1_b_resp = resp; end
            bn++;
            #1;
            seen |= {m0_aw_valid, m0_w_valid, m1_aw_valid, m1_w_valid};
            if (slv_b_valid) begin vc++; if (vc > br_lat) slv_b_ready = 1; end
            #1;
            if (slv_b_valid && slv_b_ready) begin done = 1; bcnt++; got_resp = slv_b_resp; end
            @(posedge clk_i); #1;
        end
        slv_b_ready = 0; m0_b_valid = 0; m1_b_valid = 0;
        #1;
        if (slv_b_valid) bcnt++;
    endtask

    task automatic test_reset();
        slv_ar_valid = 1; slv_aw_valid = 1; slv_w_valid = 1;
        m0_ar_ready = 1; m1_ar_ready = 1; m0_r_valid = 1; m1_b_valid = 1;
        #3;
        n_cmp++; if (outs !== 15'h0) begin n_bad++; $display("FAIL reset_outs: got %h want %h", outs, 15'h0); end
        @(posedge clk_i); #1;
        slv_ar_valid = 0; slv_aw_valid = 0; slv_w_valid = 0;
        m0_ar_ready = 0; m1_ar_ready = 0; m0_r_valid = 0; m1_b_valid = 0;
        rst_i = 1;
        @(posedge clk_i); #1;
        n_cmp++; if (outs !== 15'h0) begin n_bad++; $display("FAIL post_reset_idle: got %h want %h", outs, 15'h0); end
    endtask

    task automatic test_read_s0();
        logic d, s0, s1, h; logic [31:0] rd, sa; logic [1:0] rr; int v;
        rd_xact(32'h8000_0010, 2, 1, 0, 32'hDEADBEEF, 2'b00, d, rd, rr, s0, s1, sa, v, h);
        n_cmp++; if (d !== 1'b1) begin n_bad++; $display("FAIL rd_s0_done: got %b want 1", d); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_s0_data: got %h want deadbeef", rd); end
        n_cmp++; if (rr !== 2'b00) begin n_bad++; $display("FAIL rd_s0_resp: got %b want 00", rr); end
        n_cmp++; if ({s0, s1} !== 2'b10) begin n_bad++; $display("FAIL rd_s0_route: got m0/m1 %b want 10", {s0, s1}); end
        n_cmp++; if (sa !== 32'h8000_0010) begin n_bad++; $display("FAIL rd_s0_addr: got %h want 80000010", sa); end
    endtask

    task automatic test_write_s1();
        logic d; logic [1:0] br; logic [3:0] sn, ss; logic [31:0] sa, sd; int bc;
        wr_xact(32'ha000_03f8, 32'h41, 4'b0001, 2, 0, 1, 0, 2'b00, d, br, sn, sa, sd, ss, bc);
        n_cmp++; if (d !== 1'b1) begin n_bad++; $display("FAIL wr_s1_done: got %b want 1", d); end
        n_cmp++; if (br !== 2'b00) begin n_bad++; $display("FAIL wr_s1_resp: got %b want 00", br); end
        n_cmp++; if (bc !== 1) begin n_bad++; $display("FAIL wr_s1_bcount: got %0d want 1", bc); end
        n_cmp++; if (sn !== 4'b0011) begin n_bad++; $display("FAIL wr_s1_route: got %b want 0011", sn); end
        n_cmp++; if ({sa, sd, ss} !== {32'ha000_03f8, 32'h41, 4'b0001}) begin
            n_bad++; $display("FAIL wr_s1_payload: got %h %h %b want a00003f8 00000041 0001", sa, sd, ss); end
    endtask

    task automatic test_unmapped_read();
        logic d, s0, s1, h; logic [31:0] rd, sa; logic [1:0] rr; int v;
        rd_xact(32'h0000_1000, 0, 0, 5, 32'hFFFF_FFFF, 2'b00, d, rd, rr, s0, s1, sa, v, h);
        n_cmp++; if (d !== 1'b1) begin n_bad++; $display("FAIL unm_rd_done: got %b want 1", d); end
        n_cmp++; if ({s0, s1} !== 2'b00) begin n_bad++; $display("FAIL unm_rd_route: got m0/m1 %b want 00", {s0, s1}); end
        n_cmp++; if ({rd, rr} !== {32'h0, 2'b11}) begin n_bad++; $display("FAIL unm_rd_rsp: got %h/%b want 00000000/11", rd, rr); end
        n_cmp++; if (v !== 6 || h !== 1'b1) begin n_bad++; $display("FAIL unm_rd_hold: got %0d cycles held=%b want 6 held=1", v, h); end
    endtask

    task automatic test_boundary();
        logic d, s0, s1, h; logic [31:0] rd, sa, sd; logic [1:0] rr; logic [3:0] sn, ss; int v, bc;
        rd_xact(32'h87FF_FFFC, 0, 0, 0, 32'h1234_5678, 2'b00, d, rd, rr, s0, s1, sa, v, h);
        n_cmp++; if ({d, s0, s1, rr, rd} !== {3'b110, 2'b00, 32'h1234_5678}) begin
            n_bad++; $display("FAIL bnd_rd_s0_top: got done/m0/m1 %b resp %b data %h want 110 00 12345678", {d, s0, s1}, rr, rd); end
        rd_xact(32'h8800_0000, 0, 0, 0, 32'h1234_5678, 2'b00, d, rd, rr, s0, s1, sa, v, h);
        n_cmp++; if ({d, s0, s1, rr, rd} !== {3'b100, 2'b11, 32'h0}) begin
            n_bad++; $display("FAIL bnd_rd_s0_end: got done/m0/m1 %b resp %b data %h want 100 11 00000000", {d, s0, s1}, rr, rd); end
        wr_xact(32'ha000_FFFC, 32'hCAFE, 4'hF, 0, 0, 0, 0, 2'b00, d, rr, sn, sa, sd, ss, bc);
        n_cmp++; if ({d, sn, rr} !== {1'b1, 4'b0011, 2'b00}) begin
            n_bad++; $display("FAIL bnd_wr_s1_top: got done %b seen %b resp %b want 1 0011 00", d, sn, rr); end
        wr_xact(32'ha001_0000, 32'hCAFE, 4'hF, 0, 0, 0, 0, 2'b00, d, rr, sn, sa, sd, ss, bc);
        n_cmp++; if ({d, sn, rr} !== {1'b1, 4'b0000, 2'b11}) begin
            n_bad++; $display("FAIL bnd_wr_s1_end: got done %b seen %b resp %b want 1 0000 11", d, sn, rr); end
    endtask

    task automatic test_concurrent();
        logic rdn, s0, s1, h, wdn; logic [31:0] rd, ra, wa, wd; logic [1:0] rr, wr; logic [3:0] sn, ss; int v, bc;
        fork
            rd_xact(32'h8000_0000, 3, 2, 1, 32'h1122_3344, 2'b00, rdn, rd, rr, s0, s1, ra, v, h);
            wr_xact(32'ha000_0000, 32'h55, 4'hF, 0, 1, 2, 0, 2'b10, wdn, wr, sn, wa, wd, ss, bc);
        join
        n_cmp++; if ({rdn, s0, s1, rr, rd} !== {3'b110, 2'b00, 32'h1122_3344}) begin
            n_bad++; $display("FAIL conc_rd: got done/m0/m1 %b resp %b data %h want 110 00 11223344", {rdn, s0, s1}, rr, rd); end
        n_cmp++; if ({wdn, sn, wr, bc} !== {1'b1, 4'b0011, 2'b10, 1}) begin
            n_bad++; $display("FAIL conc_wr: got done %b seen %b resp %b bcnt %0d want 1 0011 10 1", wdn, sn, wr, bc); end
    endtask

    task automatic test_reset_mid_read();
        logic d, s0, s1, h; logic [31:0] rd, sa; logic [1:0] rr; int v;
        slv_ar_addr = 32'h8000_0008; slv_ar_valid = 1; m0_ar_ready = 1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        slv_ar_valid = 0; m0_ar_ready = 0; m0_r_valid = 1; m0_r_data = 32'hAAAA_5555;
        #1;
        n_cmp++; if (slv_r_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_rsp: got r_valid %b want 1", slv_r_valid); end
        #2; rst_i = 0; #1;
        n_cmp++; if (outs !== 15'h0) begin n_bad++; $display("FAIL rstmid_async_drop: got %h want %h", outs, 15'h0); end
        m0_r_valid = 0;
        @(posedge clk_i); #1;
        rst_i = 1;
        @(posedge clk_i); #1;
        rd_xact(32'h8000_0004, 1, 0, 0, 32'h0BAD_F00D, 2'b00, d, rd, rr, s0, s1, sa, v, h);
        n_cmp++; if ({d, s0, s1, rr, rd, sa} !== {3'b110, 2'b00, 32'h0BAD_F00D, 32'h8000_0004}) begin
            n_bad++; $display("FAIL rstmid_recover: got %b %b %h %h want 110 00 0badf00d 80000004", {d, s0, s1}, rr, rd, sa); end
    endtask

    initial begin
        test_reset();
        test_read_s0();
        test_write_s1();
        test_unmapped_read();
        test_boundary();
        test_concurrent();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
